regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Shares the single register-file access port (one combinational read, one write) between up to three requesters: core commit, memory-load return, interrupt context save/restore.
- Sits between the CPU phase logic and the register file inside the MCU core.
- Provides registered grant, registered write drive, and read-data return with valid.
- Supports fixed core priority or round-robin, plus bounded burst locking.

Parameters:
N_REQ, 3, number of requesters; index 0 is the core.
AW, 4, register address width.
DW, 16, data width.
CORE_PRIORITY, 1, 1 = requester 0 wins all non-locked arbitration; 0 = pure round-robin.
MAX_LOCK, 8, maximum consecutive grants to one locked owner.

Ports:
CLK  in  1  system clock; all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
REQ  in  N_REQ  per-requester access request.
LOCK  in  N_REQ  per-requester burst hold.
WE  in  N_REQ  1 = write, 0 = read.
ADDR  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW].
WDATA  in  N_REQ*DW  packed write data.
GNT  out  N_REQ  one-hot grant; 1-cycle pulse per access.
RVALID  out  N_REQ  one-hot read-data valid.
RDATA  out  DW  read data.
RF_ADDR  out  AW  register file address.
RF_WDATA  out  DW  register file write data.
RF_WE  out  1  register file write enable.
RF_RDATA  in  DW  register file combinational read data.
BUSY  out  1  OR of GNT and RVALID.

Behaviour:
- Reset (synchronous): GNT, RVALID, RDATA, RF_ADDR, RF_WDATA, RF_WE = 0; BUSY = 0; state IDLE; round-robin pointer = N_REQ-1; lock counter = 0.
- States:
  - IDLE: no grant is outstanding.
  - GRANT: GNT is high this cycle.
  - LOCKED: GNT is high and the owner holds lock.
- Arbitration in cycle t on sampled REQ produces a winner w:
  - GNT[w] = 1 in cycle t+1.
  - RF_ADDR, RF_WDATA, RF_WE = WE[w] are registered from cycle-t inputs and are valid in t+1 only.
  - RF_WE returns to 0 when no grant is issued.
- Masking: a requester whose GNT is high in cycle t is excluded from cycle-t arbitration, unless it holds LOCK and REQ.
- Winner selection:
  - If a lock continuation is eligible, the owner wins.
  - Otherwise, if CORE_PRIORITY=1 and REQ[0] is unmasked, requester 0 wins.
  - Otherwise, round-robin searches from pointer+1 upward, wrapping modulo N_REQ.
  - The pointer updates to w on every grant, including core-priority and lock grants.
- Lock rules:
  - An owner with GNT, LOCK and REQ all high is regranted the next cycle. This overrides CORE_PRIORITY.
  - The lock counter increments per consecutive grant.
  - On reaching MAX_LOCK, the lock is forcibly broken: the owner is masked for one arbitration cycle and the counter clears.
  - The counter also clears when LOCK or REQ drops.
- Transitions:
  - IDLE→GRANT when any REQ is eligible.
  - GRANT→GRANT when another requester is eligible.
  - GRANT→LOCKED when the lock continues.
  - LOCKED→LOCKED while the lock holds and the counter is below MAX_LOCK.
  - Otherwise return to GRANT, or to IDLE if no REQ is eligible.
- Requester contract:
  - Hold REQ and payload stable until GNT is seen.
  - A sampled request is committed: withdrawing REQ after sampling still yields the grant.
- Read return: in a grant cycle with RF_WE=0, RF_RDATA is captured at the cycle end. RDATA is then valid and RVALID[w]=1 in t+2 for one cycle. RDATA holds its value otherwise.
- Back-to-back: a write to Rn in cycle t+1 followed by a read of Rn granted in t+2 returns the new value; the register file writes at the edge ending t+1.
- Reset mid-access:
  - A write presented in the reset cycle completes at that edge (the register file is external).
  - All grants, RVALID and lock state clear on the following cycle.
  - A pending RVALID is dropped.

Optional Feature:
RF_ARB_STATS_EN
- Defined: adds input STAT_CLR (1) and outputs STAT_GRANTS (16) and STAT_CONFLICTS (16).
  - STAT_GRANTS counts issued grants.
  - STAT_CONFLICTS counts cycles where at least one asserted REQ was not selected.
  - Both counters saturate at 0xFFFF and clear on RESET or STAT_CLR. STAT_CLR has priority over increment.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- After reset, pulse REQ[1] write R3=0x1234 → GNT[1] at t+1 with RF_WE=1, RF_ADDR=3, RF_WDATA=0x1234; BUSY=1.
- REQ[2] reads R3 immediately after the write → GNT[2] next cycle; RVALID[2]=1 with RDATA=0x1234 one cycle after the grant.
- CORE_PRIORITY=0, REQ=3'b111 held continuously with pointer at reset value → grant order 0,1,2,0,1,2; no requester granted on consecutive cycles.
- CORE_PRIORITY=1, REQ[0] and REQ[1] continuous → grants alternate 0,1,0,1 (the masking rule prevents REQ[0] from starving REQ[1]).
- REQ[2] with LOCK[2] held, MAX_LOCK=8, REQ[0] pending → eight consecutive GNT[2], then GNT[0]; the lock counter restarts afterwards.
- RESET asserted in the cycle between a read grant and its RVALID → no RVALID; all outputs are 0 next cycle. With RF_ARB_STATS_EN defined, STAT_GRANTS=0.

Source files
------------

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: requester bundle plus the shared register-file port
interface regfile_port_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW = 4,
  parameter int DW = 16
);
  logic [N_REQ-1:0] req, lock, we, gnt, rvalid;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [DW-1:0] rdata, rf_wdata, rf_rdata;
  logic [AW-1:0] rf_addr;
  logic rf_we, busy;
  modport master (
    output req, lock, we, addr, wdata, rf_rdata,
    input gnt, rvalid, rdata, rf_addr, rf_wdata, rf_we, busy
  );
  modport slave (
    input req, lock, we, addr, wdata, rf_rdata,
    output gnt, rvalid, rdata, rf_addr, rf_wdata, rf_we, busy
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares one register-file port among N_REQ requesters; RF_ARB_STATS_EN adds grant/conflict counters
module regfile_port_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW = 4,
  parameter int DW = 16,
  parameter int CORE_PRIORITY = 1,
  parameter int MAX_LOCK = 8
) (
  input logic clk,
  input logic rst,
  regfile_port_arbiter_if.slave bus
`ifdef RF_ARB_STATS_EN
  ,
  input logic stat_clr,
  output logic [15:0] stat_grants,
  output logic [15:0] stat_conflicts
`endif
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, win, idx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [N_REQ-1:0] elig, win_oh;
  logic hold, brk, cont, found;
  assign bus.busy = |{bus.gnt, bus.rvalid};
  // ptr always names the current owner while a grant is out; lock continuation beats priority, a full burst masks the owner once
  always_comb begin
    hold = state != IDLE && bus.req[ptr] && bus.lock[ptr];
    brk = hold && int'(cnt) + 1 >= MAX_LOCK;
    cont = hold && !brk;
    elig = bus.req & ~(bus.gnt & {N_REQ{!cont}});
    win = ptr;
    idx = ptr;
    found = cont;
    if (!cont && CORE_PRIORITY != 0 && elig[0]) begin
      win = '0;
      found = 1'b1;
    end
    for (int k = 1; k <= N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!found && elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
    win_oh = found ? N_REQ'(1) << win : '0;
    cnt_nx = cont ? cnt + 1'b1 : '0;
    state_nx = !found ? IDLE : cont ? LOCKED : GRANT;
  end
  // state, grant and register-file drive; a read grant captures RF data at its cycle end for next-cycle return
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      ptr <= PW'(N_REQ - 1);
      cnt <= '0;
      bus.gnt <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
      bus.rf_addr <= '0;
      bus.rf_wdata <= '0;
      bus.rf_we <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.gnt <= win_oh;
      bus.rf_we <= found && bus.we[win];
      if (found) begin
        ptr <= win;
        bus.rf_addr <= bus.addr[win*AW +: AW];
        bus.rf_wdata <= bus.wdata[win*DW +: DW];
      end
      bus.rvalid <= bus.rf_we ? '0 : bus.gnt;
      if (|bus.gnt && !bus.rf_we) bus.rdata <= bus.rf_rdata;
    end
`ifdef RF_ARB_STATS_EN
  // saturating usage counters; clear wins over increment
  always_ff @(posedge clk)
    if (rst || stat_clr) begin
      stat_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      if (found && stat_grants != 16'hFFFF) stat_grants <= stat_grants + 1'b1;
      if (|(bus.req & ~win_oh) && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 1'b1;
    end
`endif
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: scoreboard bench for regfile_port_arbiter (core-priority and round-robin instances)
module tb_regfile_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  regfile_port_arbiter_if bus ();
  regfile_port_arbiter_if rr ();
`ifdef RF_ARB_STATS_EN
  logic stat_clr = 1'b0;
  logic [15:0] sg, sc, sg_rr, sc_rr;
`endif
  regfile_port_arbiter #(.CORE_PRIORITY(1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef RF_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(sg), .stat_conflicts(sc)
`endif
  );
  regfile_port_arbiter #(.CORE_PRIORITY(0)) dut_rr (
    .clk(clk), .rst(rst), .bus(rr)
`ifdef RF_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grants(sg_rr), .stat_conflicts(sc_rr)
`endif
  );
  logic [15:0] rf [16];
  always @(posedge clk) if (bus.rf_we) rf[bus.rf_addr] <= bus.rf_wdata;
  assign bus.rf_rdata = rf[bus.rf_addr];
  assign rr.rf_rdata = '0;
  typedef struct {
    int c;
    logic [2:0] v;
    logic we;
    logic [3:0] a;
    logic [15:0] d;
  } ev_t;
  ev_t qg[$], qr[$], qx[$];
  ev_t eg_e, er_e, ex_e;
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic push(input int q, input int c, input logic [2:0] v, input logic we, input logic [3:0] a, input logic [15:0] d);
    ev_t t;
    t.c = c; t.v = v; t.we = we; t.a = a; t.d = d;
    if (q == 0) qg.push_back(t);
    else if (q == 1) qr.push_back(t);
    else qx.push_back(t);
  endtask
  task automatic drv(input logic [2:0] r, l, w, input logic [11:0] a, input logic [47:0] d);
    bus.req = r; bus.lock = l; bus.we = w; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) drv(3'b000, 3'b000, 3'b000, 12'h000, 48'h0);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " gnt"}, 32'(bus.gnt), 0);
    chk({tag, " rvalid"}, 32'(bus.rvalid), 0);
    chk({tag, " rdata"}, 32'(bus.rdata), 0);
    chk({tag, " rf_addr"}, 32'(bus.rf_addr), 0);
    chk({tag, " rf_wdata"}, 32'(bus.rf_wdata), 0);
    chk({tag, " rf_we"}, 32'(bus.rf_we), 0);
    chk({tag, " busy"}, 32'(bus.busy), 0);
`ifdef RF_ARB_STATS_EN
    chk({tag, " stat_grants"}, 32'(sg), 0);
`endif
  endtask
  always @(negedge clk) begin
    if (|bus.gnt) begin
      if (qg.size() == 0) chk("gnt unexpected", 32'(bus.gnt), 0);
      else begin
        eg_e = qg.pop_front();
        chk("gnt cycle", cyc, eg_e.c);
        chk("gnt", 32'(bus.gnt), 32'(eg_e.v));
        chk("rf_we", 32'(bus.rf_we), 32'(eg_e.we));
        chk("rf_addr", 32'(bus.rf_addr), 32'(eg_e.a));
        chk("rf_wdata", 32'(bus.rf_wdata), 32'(eg_e.d));
        chk("busy", 32'(bus.busy), 1);
      end
    end else chk("idle rf_we", 32'(bus.rf_we), 0);
    if (|bus.rvalid) begin
      if (qr.size() == 0) chk("rvalid unexpected", 32'(bus.rvalid), 0);
      else begin
        er_e = qr.pop_front();
        chk("rvalid cycle", cyc, er_e.c);
        chk("rvalid", 32'(bus.rvalid), 32'(er_e.v));
        chk("rdata", 32'(bus.rdata), 32'(er_e.d));
      end
    end
    if (|rr.gnt) begin
      if (qx.size() == 0) chk("rr gnt unexpected", 32'(rr.gnt), 0);
      else begin
        ex_e = qx.pop_front();
        chk("rr gnt cycle", cyc, ex_e.c);
        chk("rr gnt", 32'(rr.gnt), 32'(ex_e.v));
        chk("rr rf_addr", 32'(rr.rf_addr), 32'(ex_e.a));
        chk("rr rf_wdata", 32'(rr.rf_wdata), 32'(ex_e.d));
      end
    end
    if (|rr.rvalid) chk("rr rvalid unexpected", 32'(rr.rvalid), 0);
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    bus.req = '0; bus.lock = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    rr.req = '0; rr.lock = '0; rr.we = '0; rr.addr = '0; rr.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    idle(1);
    // round-robin instance, all three requesting continuously from reset pointer
    for (int i = 0; i < 6; i++)
      push(2, cyc + 1 + i, 3'(1 << (i % 3)), 1'b1, 4'(i % 3 + 1), 16'hA000 + 16'(i % 3));
    rr.req = 3'b111; rr.we = 3'b111; rr.addr = 12'h321; rr.wdata = 48'hA002_A001_A000;
    repeat (6) @(posedge clk);
    #1;
    rr.req = '0; rr.we = '0;
    idle(2);
    // write R3 then immediate read of R3 by another requester
    push(0, cyc + 1, 3'b010, 1'b1, 4'd3, 16'h1234);
    drv(3'b010, 3'b000, 3'b010, 12'h030, 48'h0000_1234_0000);
    push(0, cyc + 1, 3'b100, 1'b0, 4'd3, 16'h0000);
    push(1, cyc + 2, 3'b100, 1'b0, 4'd0, 16'h1234);
    drv(3'b100, 3'b000, 3'b000, 12'h300, 48'h0);
    idle(3);
    // core write then read of R5: read is masked one cycle behind its own grant
    push(0, cyc + 1, 3'b001, 1'b1, 4'd5, 16'hBEEF);
    drv(3'b001, 3'b000, 3'b001, 12'h005, 48'h0000_0000_BEEF);
    drv(3'b001, 3'b000, 3'b000, 12'h005, 48'h0);
    push(0, cyc + 1, 3'b001, 1'b0, 4'd5, 16'h0000);
    push(1, cyc + 2, 3'b001, 1'b0, 4'd0, 16'hBEEF);
    drv(3'b001, 3'b000, 3'b000, 12'h005, 48'h0);
    idle(3);
    // core priority with masking: 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push(0, cyc + 1, 3'b001, 1'b1, 4'd1, 16'h1111);
      else push(0, cyc + 1, 3'b010, 1'b1, 4'd2, 16'h2222);
      drv(3'b011, 3'b000, 3'b011, 12'h021, 48'h0000_2222_1111);
    end
    idle(3);
    chk("rdata hold", 32'(bus.rdata), 32'h0000BEEF);
    // locked burst by requester 2 against pending core: 8x2, 0, 8x2, 0
    push(0, cyc + 1, 3'b100, 1'b1, 4'd7, 16'h7777);
    drv(3'b100, 3'b100, 3'b100, 12'h700, 48'h7777_0000_0000);
    for (int i = 0; i < 17; i++) begin
      if (i == 7 || i == 16) push(0, cyc + 1, 3'b001, 1'b1, 4'd8, 16'h0808);
      else push(0, cyc + 1, 3'b100, 1'b1, 4'd7, 16'h7777);
      drv(3'b101, 3'b100, 3'b101, 12'h708, 48'h7777_0000_0808);
    end
    idle(3);
    // reset between a read grant and its return
    push(0, cyc + 1, 3'b010, 1'b0, 4'd3, 16'h0000);
    drv(3'b010, 3'b000, 3'b000, 12'h030, 48'h0);
    rst = 1'b1;
    idle(1);
    chk_zero("mid reset");
    rst = 1'b0;
    idle(3);
    chk("grants left", qg.size(), 0);
    chk("rvalids left", qr.size(), 0);
    chk("rr grants left", qx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
